display_sequencer: RTL and testbench

Sequences the VGA pixel path across three display phases and shares the single-port pixel RAM between the scan-out reader and the systolic-array NPU. Sits between the VGA timing generator (hs/vs counters), the pixel RAM, and the NPU control port. A debounced ok_button press shows the 400×400 input image, starts the NPU, and then shows the 200×200 result image. While the NPU runs, it receives the RAM only in cycles the display does not need.

---
 rtl/display_sequencer.sv | 162 ++++++++++++++++
 tb/tb_display_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_sequencer.sv
// Display phase sequencer: debounced start button, SHOW_IN/START/BUSY/SHOW_RES FSM,
// and pixel-RAM arbitration between VGA scan-out (priority) and the NPU.
module display_sequencer #(
    parameter int IMG_W      = 400,
    parameter int IMG_X0     = 120,
    parameter int IMG_Y0     = 40,
    parameter int RES_W      = 200,
    parameter int RES_X0     = 220,
    parameter int RES_Y0     = 140,
    parameter int RES_BASE   = 160000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ok_button,
    input  logic [9:0]  hs,
    input  logic [9:0]  vs,
    input  logic [7:0]  pixel_data,
    output logic [17:0] pixel_address,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        npu_start,
    input  logic        npu_done,
    input  logic        npu_req,
    input  logic        npu_we,
    input  logic [17:0] npu_addr,
    input  logic [7:0]  npu_wdata,
    output logic        npu_gnt,
    output logic        npu_rvalid,
    output logic [1:0]  mode
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        SHOW_IN  = 2'd0,
        START    = 2'd1,
        BUSY     = 2'd2,
        SHOW_RES = 2'd3
    } state_t;

    state_t        state;
    logic          btn_s1, btn_s2, btn_level, press;
    logic [CW-1:0] deb_cnt;

    // Button: two-flop synchronizer, then accept a new level only after
    // DEB_CYCLES consecutive samples that disagree with the current one.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop in this block samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1    <= 1'b0;
            btn_s2    <= 1'b0;
            btn_level <= 1'b0;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            btn_s1 <= ok_button;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            if (btn_s2 == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
                deb_cnt   <= '0;
                btn_level <= btn_s2;
                press     <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= SHOW_IN;
            npu_start <= 1'b0;
        end else begin
            npu_start <= 1'b0;
            case (state)
                SHOW_IN:  if (press) begin
                              state     <= START;
                              npu_start <= 1'b1;
                          end
                START:    state <= BUSY;
                BUSY:     if (npu_done) state <= SHOW_RES;
                SHOW_RES: if (press) state <= SHOW_IN;
                default:  state <= SHOW_IN;
            endcase
        end
    end

    assign mode = state;

    logic        in_win, res_win, disp_act, npu_grant;
    logic [9:0]  in_row, in_col, res_row, res_col;
    logic [17:0] disp_addr;

    // NOTE: every output of this block is assigned on every path, so no
    // latch can be inferred.
    always_comb begin
        in_win  = (hs >= 10'(IMG_X0)) && (hs < 10'(IMG_X0 + IMG_W)) &&
                  (vs >= 10'(IMG_Y0)) && (vs < 10'(IMG_Y0 + IMG_W));
        res_win = (hs >= 10'(RES_X0)) && (hs < 10'(RES_X0 + RES_W)) &&
                  (vs >= 10'(RES_Y0)) && (vs < 10'(RES_Y0 + RES_W));
        in_row  = vs - 10'(IMG_Y0);
        in_col  = hs - 10'(IMG_X0);
        res_row = vs - 10'(RES_Y0);
        res_col = hs - 10'(RES_X0);
        if (state == SHOW_RES) begin
            disp_act  = res_win;
            disp_addr = 18'(RES_BASE) + 18'(res_row) * 18'(RES_W) + 18'(res_col);
        end else begin
            disp_act  = in_win;
            disp_addr = 18'(in_row) * 18'(IMG_W) + 18'(in_col);
        end
        npu_grant = !disp_act && (state == BUSY) && npu_req;
    end

    logic       act_d1, act_d2, rd_pend;
    logic [7:0] pix_q;

    // The window flag travels two stages to meet pixel_data; a reset drops any
    // outstanding NPU read so its rvalid never appears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixel_address <= '0;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            npu_gnt       <= 1'b0;
            rd_pend       <= 1'b0;
            npu_rvalid    <= 1'b0;
            act_d1        <= 1'b0;
            act_d2        <= 1'b0;
            pix_q         <= '0;
        end else begin
            mem_we  <= 1'b0;
            npu_gnt <= 1'b0;
            rd_pend <= 1'b0;
            if (disp_act) begin
                pixel_address <= disp_addr;
            end else if (npu_grant) begin
                pixel_address <= npu_addr;
                mem_we        <= npu_we;
                mem_wdata     <= npu_wdata;
                npu_gnt       <= 1'b1;
                rd_pend       <= !npu_we;
            end
            npu_rvalid <= rd_pend;
            act_d1     <= disp_act;
            act_d2     <= act_d1;
            pix_q      <= act_d2 ? pixel_data : 8'h00;
        end
    end

    assign r = pix_q;
    assign g = pix_q;
    assign b = pix_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Self-checking bench for display_sequencer: directed scenarios plus randomized scan
// and NPU traffic compared each cycle against a behavioural model of the sequencer.
module tb_display_sequencer;

    localparam int IMG_W = 400, IMG_X0 = 120, IMG_Y0 = 40;
    localparam int RES_W = 200, RES_X0 = 220, RES_Y0 = 140;
    localparam int RES_BASE = 160000;
    localparam int DEB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ok_button = 1'b0;
    logic [9:0]  hs = '0, vs = '0;
    logic [7:0]  pixel_data = '0;
    logic [17:0] pixel_address;
    logic        mem_we;
    logic [7:0]  mem_wdata, r, g, b;
    logic        npu_start;
    logic        npu_done = 1'b0;
    logic        npu_req = 1'b0, npu_we = 1'b0;
    logic [17:0] npu_addr = '0;
    logic [7:0]  npu_wdata = '0;
    logic        npu_gnt, npu_rvalid;
    logic [1:0]  mode;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;
    bit npu_auto = 1'b0;
    bit rnd_pos  = 1'b0;

    display_sequencer #(
        .IMG_W(IMG_W), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
        .RES_W(RES_W), .RES_X0(RES_X0), .RES_Y0(RES_Y0),
        .RES_BASE(RES_BASE), .DEB_CYCLES(DEB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ok_button(ok_button), .hs(hs), .vs(vs),
        .pixel_data(pixel_data), .pixel_address(pixel_address), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .r(r), .g(g), .b(b), .npu_start(npu_start),
        .npu_done(npu_done), .npu_req(npu_req), .npu_we(npu_we), .npu_addr(npu_addr),
        .npu_wdata(npu_wdata), .npu_gnt(npu_gnt), .npu_rvalid(npu_rvalid), .mode(mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] pat(input int a);
        return 8'((a ^ (a >> 8) ^ 32'h5A) & 32'hFF);
    endfunction

    // Pixel RAM: one-cycle read latency, read returns the pre-write contents.
    logic [7:0] ram_w [int];
    always @(posedge clk) begin
        int a;
        a = int'(pixel_address);
        pixel_data <= ram_w.exists(a) ? ram_w[a] : pat(a);
        if (mem_we) ram_w[a] = mem_wdata;
    end

    // Reference model: expected output values after each edge, derived from
    // the window/address arithmetic and the phase rules.
    logic [7:0] shd_w [int];
    int         m_state = 0;
    logic       m_d1 = 0, m_d2 = 0, m_level = 0, m_press = 0;
    int         m_run = 0;
    logic [17:0] e_addr = '0;
    logic        e_we = 0, e_gnt = 0, e_rd1 = 0, e_rvalid = 0, e_act1 = 0, e_act2 = 0, e_start = 0;
    logic [7:0]  e_wdata = '0, e_pdata = '0, e_r = '0;

    always @(posedge clk) begin
        logic [7:0] old_pdata;
        logic       synced, act, flip;
        int         a, x, y;
        old_pdata = e_pdata;
        a = int'(e_addr);
        e_pdata = shd_w.exists(a) ? shd_w[a] : pat(a);
        if (e_we) shd_w[a] = e_wdata;
        if (!rst_n) begin
            m_state = 0; m_d1 = 0; m_d2 = 0; m_level = 0; m_press = 0; m_run = 0;
            e_addr = '0; e_we = 0; e_wdata = '0; e_gnt = 0; e_rd1 = 0; e_rvalid = 0;
            e_act1 = 0; e_act2 = 0; e_start = 0; e_r = '0;
        end else begin
            e_r      = e_act2 ? old_pdata : 8'h00;
            e_rvalid = e_rd1;
            e_act2   = e_act1;
            x = int'(hs);
            y = int'(vs);
            if (m_state == 3) begin
                act = x >= RES_X0 && x < RES_X0 + RES_W && y >= RES_Y0 && y < RES_Y0 + RES_W;
                a   = RES_BASE + (y - RES_Y0) * RES_W + (x - RES_X0);
            end else begin
                act = x >= IMG_X0 && x < IMG_X0 + IMG_W && y >= IMG_Y0 && y < IMG_Y0 + IMG_W;
                a   = (y - IMG_Y0) * IMG_W + (x - IMG_X0);
            end
            e_gnt = 0; e_we = 0; e_rd1 = 0;
            if (act) e_addr = 18'(a);
            else if (m_state == 2 && npu_req) begin
                e_addr = npu_addr; e_we = npu_we; e_wdata = npu_wdata;
                e_gnt = 1; e_rd1 = !npu_we;
            end
            e_act1  = act;
            e_start = (m_state == 0) && m_press;
            case (m_state)
                0: if (m_press) m_state = 1;
                1: m_state = 2;
                2: if (npu_done) m_state = 3;
                default: if (m_press) m_state = 0;
            endcase
            synced = m_d2; m_d2 = m_d1; m_d1 = ok_button;
            flip = 0;
            if (synced != m_level) begin
                m_run++;
                if (m_run == DEB) begin flip = 1; m_run = 0; m_level = synced; end
            end else m_run = 0;
            m_press = flip && m_level;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("addr", 32'(pixel_address), 32'(e_addr));
            check("we", 32'(mem_we), 32'(e_we));
            check("wdata", 32'(mem_wdata), 32'(e_wdata));
            check("r", 32'(r), 32'(e_r));
            check("g", 32'(g), 32'(e_r));
            check("b", 32'(b), 32'(e_r));
            check("start", 32'(npu_start), 32'(e_start));
            check("gnt", 32'(npu_gnt), 32'(e_gnt));
            check("rvalid", 32'(npu_rvalid), 32'(e_rvalid));
            check("mode", 32'(mode), 32'(m_state));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (npu_auto && (!npu_req || npu_gnt)) begin
            npu_req   = 1'($urandom_range(0, 1));
            npu_we    = 1'($urandom_range(0, 1));
            npu_addr  = 18'($urandom_range(0, 999));
            npu_wdata = 8'($urandom);
        end
        if (rnd_pos) begin
            hs = 10'($urandom_range(0, 799));
            vs = 10'($urandom_range(0, 524));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_button(input logic [1:0] target, input string tag);
        int  lat;
        bit  seen;
        seen = 0; lat = 0;
        ok_button = 1'b1;
        for (int i = 0; i < DEB + 20; i++) begin
            step();
            lat++;
            if (mode == target) begin seen = 1; break; end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat_ok"}, 32'(lat >= DEB + 1 && lat <= DEB + 4), 32'd1);
    endtask

    task automatic release_button();
        steps(DEB + 4);
        ok_button = 1'b0;
        steps(2 * DEB + 6);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        step();
        chk_en = 1'b1;
        steps(2);
        check("rst_addr", 32'(pixel_address), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_rgb", 32'({r, g, b}), 32'd0);
        rst_n = 1'b1;

        hs = 10'd120; vs = 10'd40; step();
        check("first_pixel_addr", 32'(pixel_address), 32'd0);
        hs = 10'd0; vs = 10'd0; steps(2);
        check("first_pixel_rgb", 32'(r), 32'(pat(0)));
        hs = 10'd519; vs = 10'd439; step();
        check("last_in_addr", 32'(pixel_address), 32'd159999);
        hs = 10'd520; step();
        check("right_edge_hold", 32'(pixel_address), 32'd159999);
        steps(2);
        check("right_edge_black", 32'(r), 32'd0);

        rnd_pos = 1'b1; npu_auto = 1'b1;
        steps(300);

        ok_button = 1'b1; steps(DEB - 1);
        ok_button = 1'b0; steps(DEB + 10);
        check("glitch_mode", 32'(mode), 32'd0);

        press_button(2'd1, "press_start");
        check("npu_start_pulse", 32'(npu_start), 32'd1);
        step();
        check("busy_mode", 32'(mode), 32'd2);
        check("npu_start_drop", 32'(npu_start), 32'd0);
        release_button();

        rnd_pos = 1'b0; npu_auto = 1'b0; npu_req = 1'b0;
        hs = 10'd0; vs = 10'd0; step();
        npu_req = 1'b1; npu_we = 1'b0; npu_addr = 18'd5; step();
        check("npu_gnt_out", 32'(npu_gnt), 32'd1);
        check("npu_addr_out", 32'(pixel_address), 32'd5);
        npu_req = 1'b0; step();
        check("npu_rvalid", 32'(npu_rvalid), 32'd1);

        hs = 10'd200; vs = 10'd100; npu_req = 1'b1; npu_addr = 18'd77; step();
        check("win_blocks_gnt", 32'(npu_gnt), 32'd0);
        check("win_addr", 32'(pixel_address), 32'd24080);
        hs = 10'd0; step();
        check("late_gnt", 32'(npu_gnt), 32'd1);
        check("late_addr", 32'(pixel_address), 32'd77);
        npu_req = 1'b0;

        rnd_pos = 1'b1; npu_auto = 1'b1;
        steps(800);

        npu_done = 1'b1; step();
        npu_done = 1'b0;
        check("res_mode", 32'(mode), 32'd3);
        rnd_pos = 1'b0;
        hs = 10'd220; vs = 10'd140; step();
        check("res_first_addr", 32'(pixel_address), 32'd160000);
        hs = 10'd419; vs = 10'd339; step();
        check("res_last_addr", 32'(pixel_address), 32'd199999);
        rnd_pos = 1'b1;
        steps(400);

        press_button(2'd0, "press_back");
        release_button();
        steps(100);

        press_button(2'd1, "press_again");
        step();
        release_button();
        rnd_pos = 1'b0; npu_auto = 1'b0;
        hs = 10'd0; vs = 10'd0;
        npu_req = 1'b1; npu_we = 1'b0; npu_addr = 18'd9; step();
        check("pre_rst_gnt", 32'(npu_gnt), 32'd1);
        rst_n = 1'b0; npu_req = 1'b0; step();
        check("rst_rvalid", 32'(npu_rvalid), 32'd0);
        check("rst_mid_mode", 32'(mode), 32'd0);
        check("rst_mid_addr", 32'(pixel_address), 32'd0);
        check("rst_mid_gnt", 32'(npu_gnt), 32'd0);
        rst_n = 1'b1; step();
        check("post_rst_rvalid", 32'(npu_rvalid), 32'd0);
        rnd_pos = 1'b1; npu_auto = 1'b1;
        steps(200);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
